sram_mem_controller: RTL and testbench
======================================

Name: sram_mem_controller

Overview:
- Memory-stage controller between the pipeline MEM stage and a 16-bit-wide external SRAM.
- Converts one 32-bit LDR/STR request, driven by the mem_read/mem_write decoded upstream, into two sequenced 16-bit SRAM transfers with programmable wait states.
- Deasserts ready to freeze the pipeline until the access completes.
- Single clock domain; SRAM data bus is split into in/out/oe so the bench needs no tristate.

Parameters:
- WAIT_CYCLES, 3, cycles each 16-bit half-transfer is held on the SRAM pins; legal range 1..15.
- BASE_ADDR, 1024, byte address mapped to SRAM word 0.
- SRAM_AW, 18, SRAM address width (16-bit locations).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- rd_en  in  1  MEM-stage read request (LDR)
- wr_en  in  1  MEM-stage write request (STR)
- address  in  32  byte address from ALU
- write_data  in  32  store data
- read_data  out  32  load data
- ready  out  1  1 = no access in progress; 0 = freeze pipeline
- sram_addr  out  SRAM_AW  SRAM location
- sram_we_n  out  1  SRAM write enable, active low
- sram_dq_out  out  16  data driven to SRAM
- sram_dq_oe  out  1  1 = controller drives the SRAM data bus
- sram_dq_in  in  16  data returned by SRAM

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, wait counter=0, sram_addr=0, sram_we_n=1, sram_dq_oe=0, sram_dq_out=0, read_data=0.
- Reset asserted mid-access: the access aborts immediately, sram_we_n returns to 1 asynchronously, and the access is not completed.
- Address map: widx = (address - BASE_ADDR) >> 2, truncated to SRAM_AW-1 bits. Low half is at {widx,0}, high half at {widx,1}. address[1:0] is ignored.
- States:
  - IDLE: if wr_en or rd_en, latch the op (wr_en has priority when both are high), address and write_data, go to LO. Otherwise stay.
  - LO: sram_addr={widx,0}; counter counts 0..WAIT_CYCLES-1. On the last count, go to HI and clear the counter. For a read, capture sram_dq_in into read_data[15:0] on the last count.
  - HI: same as LO using {widx,1} and read_data[31:16]. On the last count, go to DONE.
  - DONE: one cycle, then go to IDLE.
- ready (combinational):
  - 1 in DONE.
  - 1 in IDLE when rd_en=wr_en=0.
  - 0 in IDLE when a request is present.
  - 0 in LO and HI.
- Timing: for a request first seen in cycle 0, ready is low for cycles 0..2*WAIT_CYCLES and high in cycle 2*WAIT_CYCLES+1. With the default this is 7 low cycles, high in the 8th. The pipeline advances on that edge.
- Write pin behaviour: during LO/HI, sram_dq_oe=1 and sram_we_n=0 for all cycles except the last count of each phase, where sram_we_n=1 (data held, address stable). sram_dq_out is write_data[15:0] in LO and write_data[31:16] in HI.
- Read pin behaviour: sram_dq_oe=0 and sram_we_n=1 throughout.
- Idle pins: in IDLE/DONE, sram_we_n=1 and sram_dq_oe=0. sram_addr holds its last value.
- read_data holds until the next read completes; writes do not alter it.
- Request or address changes after latching are ignored until DONE.
- Back-to-back: if a request is present in the cycle after DONE (IDLE), a new access starts with no extra bubble beyond that IDLE cycle.
- WAIT_CYCLES=1: each phase lasts one cycle, so sram_we_n never asserts low; this is a legal read-only timing, and writes require WAIT_CYCLES>=2.

Test Plan:
- Reset, then idle: all outputs at reset values, ready=1 with no request.
- STR at address=1032, write_data=0xDEADBEEF: sram_addr=4 with dq_out=0xBEEF and we_n low 2 cycles; then sram_addr=5 with dq_out=0xDEAD; ready low exactly 7 cycles.
- LDR at 1032 with model returning 0xBEEF/0xDEAD: read_data=0xDEADBEEF in the DONE cycle; ready returns high in cycle 7; sram_dq_oe stays 0.
- Back-to-back LDR 1024 then STR 1028: second access starts from the IDLE cycle after DONE; sram_addr sequence 0,1,2,3; read_data unchanged by the store.
- rd_en and wr_en both high at 1040: executes a write to locations 8/9; read_data unchanged.
- rst_n pulsed low during the HI phase of a write: sram_we_n=1 and sram_dq_oe=0 immediately; state=IDLE; ready=1 once the request drops.

Source files
------------

// File: rtl/sram_mem_controller.sv
// Splits one 32-bit MEM-stage load/store into two 16-bit SRAM transfers with programmable wait states.
// Latency: 2*WAIT_CYCLES+1 cycles with ready low, then one DONE cycle with ready high.
// Backpressure: ready drops while a request is present or an access is in flight, which freezes the pipeline.
module sram_mem_controller #(
    parameter int WAIT_CYCLES = 3,
    parameter int BASE_ADDR   = 1024,
    parameter int SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic               sram_we_n,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_in
);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               is_wr_q, is_wr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [SRAM_AW-1:0] addr_q, addr_d;

    logic [31:0] offset;
    logic        last_cnt;
    logic        busy;
    logic        unused_offset_bits;

    // Byte offset from the SRAM window; bits [1:0] select a byte and are dropped.
    assign offset             = address - 32'(BASE_ADDR);
    assign unused_offset_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};
    assign last_cnt           = (cnt_q == 4'(WAIT_CYCLES - 1));
    assign busy               = (state_q == LO) || (state_q == HI);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            is_wr_q <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            is_wr_q <= is_wr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        is_wr_d = is_wr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                if (wr_en || rd_en) begin
                    is_wr_d = wr_en;
                    wdata_d = write_data;
                    addr_d  = {offset[SRAM_AW:2], 1'b0};
                    cnt_d   = '0;
                    state_d = LO;
                end
            end
            LO: begin
                if (last_cnt) begin
                    cnt_d   = '0;
                    addr_d  = {addr_q[SRAM_AW-1:1], 1'b1};
                    state_d = HI;
                    if (!is_wr_q) rdata_d[15:0] = sram_dq_in;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            HI: begin
                if (last_cnt) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    if (!is_wr_q) rdata_d[31:16] = sram_dq_in;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // we_n rises on the last count of each phase so data and address are stable at the SRAM's write edge.
    assign sram_dq_oe  = busy && is_wr_q;
    assign sram_we_n   = !(sram_dq_oe && !last_cnt);
    assign sram_dq_out = !sram_dq_oe ? 16'h0000 :
                         (state_q == LO) ? wdata_q[15:0] : wdata_q[31:16];
    assign sram_addr   = addr_q;
    assign read_data   = rdata_q;
    assign ready       = (state_q == DONE) || ((state_q == IDLE) && !rd_en && !wr_en);

endmodule

// File: tb/tb_sram_mem_controller.sv
// Directed bench for sram_mem_controller with WAIT_CYCLES=3 and a 16-location SRAM model.
module tb_sram_mem_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_en, wr_en;
    logic [31:0] address, write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic        sram_we_n;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [0:15] = '{0: 16'h1111, 1: 16'h2222, default: 16'h0000};

    always #5 clk = ~clk;

    assign sram_dq_in = mem[sram_addr[3:0]];

    // SRAM latches data on the rising edge of we_n.
    always @(posedge sram_we_n) begin
        if (sram_dq_oe) mem[sram_addr[3:0]] = sram_dq_out;
    end

    sram_mem_controller #(.WAIT_CYCLES(3), .BASE_ADDR(1024), .SRAM_AW(18)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_en       (rd_en),
        .wr_en       (wr_en),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_we_n   (sram_we_n),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_dq_in  (sram_dq_in)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_step();
        @(posedge clk); #1;
        rd_en = 1'b0; wr_en = 1'b0;
        #1;
        chk("idle_ready", 32'(ready), 32'd1);
        chk("idle_we_n", 32'(sram_we_n), 32'd1);
        chk("idle_oe", 32'(sram_dq_oe), 32'd0);
    endtask

    // Cycle c=0 presents the request; LO spans c=1..3, HI c=4..6, DONE is c=7.
    task automatic access(input logic wr, input logic rd, input logic [31:0] a,
                          input logic [31:0] wd, input logic [17:0] loc,
                          input logic [31:0] exp_rd);
        logic        ph, wph, lo;
        logic [15:0] exp_dq;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                wr_en = wr; rd_en = rd; address = a; write_data = wd;
            end else if (c == 2) begin
                address = 32'h0000_0000; write_data = 32'h0000_0000;
            end
            #1;
            ph  = (c >= 1) && (c <= 6);
            lo  = (c <= 3);
            wph = ph && wr;
            exp_dq = !wph ? 16'h0000 : (lo ? wd[15:0] : wd[31:16]);
            chk($sformatf("ready_c%0d", c), 32'(ready), 32'(c == 7));
            chk($sformatf("oe_c%0d", c), 32'(sram_dq_oe), 32'(wph));
            chk($sformatf("we_n_c%0d", c), 32'(sram_we_n), 32'(!(wph && c != 3 && c != 6)));
            chk($sformatf("dq_out_c%0d", c), 32'(sram_dq_out), 32'(exp_dq));
            if (ph) chk($sformatf("addr_c%0d", c), 32'(sram_addr), 32'(lo ? loc : loc + 18'd1));
            if (c == 7) chk("read_data_done", read_data, exp_rd);
        end
    endtask

    initial begin
        rst_n = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
        address = '0; write_data = '0;
        #12;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_addr", 32'(sram_addr), 32'd0);
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_oe", 32'(sram_dq_oe), 32'd0);
        chk("rst_dq_out", 32'(sram_dq_out), 32'd0);
        chk("rst_read_data", read_data, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        idle_step();

        // STR 1032: locations 4/5
        access(1'b1, 1'b0, 32'd1032, 32'hDEADBEEF, 18'd4, 32'h0000_0000);
        idle_step();
        chk("mem4", 32'(mem[4]), 32'h0000_BEEF);
        chk("mem5", 32'(mem[5]), 32'h0000_DEAD);

        // LDR 1032 reads back the stored word
        access(1'b0, 1'b1, 32'd1032, 32'h0, 18'd4, 32'hDEADBEEF);
        idle_step();

        // Back-to-back LDR 1024 then STR 1028
        access(1'b0, 1'b1, 32'd1024, 32'h0, 18'd0, 32'h2222_1111);
        access(1'b1, 1'b0, 32'd1028, 32'hCAFEF00D, 18'd2, 32'h2222_1111);
        idle_step();
        chk("mem2", 32'(mem[2]), 32'h0000_F00D);
        chk("mem3", 32'(mem[3]), 32'h0000_CAFE);

        // Both requests high: write wins
        access(1'b1, 1'b1, 32'd1040, 32'h12345678, 18'd8, 32'h2222_1111);
        idle_step();
        chk("mem8", 32'(mem[8]), 32'h0000_5678);
        chk("mem9", 32'(mem[9]), 32'h0000_1234);
        chk("rd_after_both", read_data, 32'h2222_1111);

        // Reset asserted during the HI phase of a write
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                wr_en = 1'b1; rd_en = 1'b0; address = 32'd1048; write_data = 32'hA5A5_5A5A;
            end
            #1;
        end
        chk("pre_rst_we_n", 32'(sram_we_n), 32'd0);
        chk("pre_rst_addr", 32'(sram_addr), 32'd13);
        rst_n = 1'b0;
        #1;
        chk("midrst_we_n", 32'(sram_we_n), 32'd1);
        chk("midrst_oe", 32'(sram_dq_oe), 32'd0);
        chk("midrst_ready_req", 32'(ready), 32'd0);
        chk("midrst_read_data", read_data, 32'd0);
        wr_en = 1'b0;
        #1;
        chk("midrst_ready_idle", 32'(ready), 32'd1);
        @(negedge clk); rst_n = 1'b1;
        idle_step();
        chk("post_rst_addr", 32'(sram_addr), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
